cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control sequencer for the 8-bit processor core. It owns the program counter, steps every instruction through FETCH/DECODE/EXECUTE/WRITEBACK, and drives the datapath control strobes (`ir_load`, `reg_write`, `pc_src`, `alu_op`). It also provides run/halt/single-step control for bring-up through the top-level `ui_in` pins. It sits between the instruction memory and the register file/ALU datapath, replacing free-running single-cycle control.

## Interface
- `PC_WIDTH`, default 4: program counter width; instruction memory has 2^PC_WIDTH words.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `run` input 1: level; while high, the sequencer executes instructions back to back.
- `step` input 1: one-cycle pulse; executes exactly one instruction from IDLE (see Configuration).
- `halt_req` input 1: level; finish the current instruction, then go to IDLE.
- `instruction` input 8: instruction word at `pc`, valid combinationally.
- `pc` output PC_WIDTH: instruction address.
- `ir_load` output 1: one-cycle strobe; datapath latches `instruction`.
- `opcode` output 2: latched `ir[7:6]`.
- `alu_op` output 3: latched `ir[5:3]`; valid from DECODE through WRITEBACK.
- `reg_write` output 1: one-cycle register-file write strobe.
- `pc_src` output 1: 1 means the PC loads the jump target this cycle.
- `busy` output 1: high in FETCH, DECODE, EXECUTE and WRITEBACK.
- `halted` output 1: high in HALTED.
- `retired` output 8: count of completed instructions; wraps 255 -> 0.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- Encoding of `ir[7:6]`:
  - 00: ALU, with `alu_op = ir[5:3]`; writes a register.
  - 01: LDI; writes a register.
  - 10: JMP, with target `ir[PC_WIDTH-1:0]`.
  - 11: SYS; `ir[5]=1` is HALT, `ir[5]=0` is NOP.
- Transitions:
  - IDLE -> FETCH when `run=1` and `halt_req=0`, or on a `step` pulse.
  - FETCH -> DECODE -> EXECUTE -> WRITEBACK, unconditionally.
  - WRITEBACK -> HALTED when the instruction is HALT.
  - Otherwise WRITEBACK -> FETCH if `run=1` and `halt_req=0` and the instruction was not started by `step`.
  - Otherwise WRITEBACK -> IDLE.
  - HALTED is left only by reset.
- FETCH: `ir_load=1` and the IR captures `instruction`.
- WRITEBACK:
  - `reg_write=1` for ALU and LDI only.
  - JMP: `pc_src=1` and `pc <= target`.
  - Every other opcode: `pc <= pc + 1` modulo 2^PC_WIDTH.
  - `retired` increments, including for HALT.
- `run` and `halt_req` are sampled only in IDLE and WRITEBACK. Changes while busy have no effect until then.
- `run`, `step` and `halt_req` high together in IDLE: stay in IDLE, because `halt_req` has priority. `run` and `step` together with `halt_req=0`: start a run.
- Reset values: `pc=RESET_PC`, IR=0, state IDLE, all strobes 0, `opcode=0`, `alu_op=0`, `busy=0`, `halted=0`, `retired=0`.
- Reset asserted mid-instruction aborts it: no `reg_write`, and `pc` is restored immediately.

## Timing
- Every instruction takes 4 cycles, FETCH through WRITEBACK.
- Back-to-back throughput: one instruction per 4 cycles, with no idle bubble.
- Start latency: `run` high at edge N means FETCH in cycle N+1.
- `pc` changes only at the end of WRITEBACK and is stable for the whole next FETCH.
- `ir_load`, `reg_write` and `pc_src` are registered outputs, each high for exactly one cycle.
- `opcode` and `alu_op` change only at the end of FETCH.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - A `step` pulse in IDLE runs exactly one instruction, then returns to IDLE regardless of `run`.
  - A `step` pulse outside IDLE is dropped.
- `SEQ_SINGLE_STEP_EN` undefined:
  - The `step` port exists but is ignored.
  - IDLE -> FETCH only via `run`.

## Structure
- Shared package `cpu_pkg` contains:
  - the state enum;
  - opcode constants `OP_ALU`, `OP_LDI`, `OP_JMP`, `OP_SYS`;
  - `ALU_OP_W = 3`;
  - the HALT bit index 5.
- One sub-module, `seq_decode`: purely combinational. It maps IR to `is_write`, `is_jump`, `is_halt` and the target.

## Test plan
- Reset and run over ALU 0x08, LDI 0x40, NOP 0xC0:
  - `ir_load` at cycles 1, 5 and 9;
  - `reg_write` at cycles 4 and 8 only;
  - `pc` reads 1, 2, 3;
  - `retired=3`.
- JMP 0x8A at `pc=3`:
  - `pc_src=1` in WRITEBACK;
  - next FETCH `pc=10`;
  - `pc=15` plus NOP wraps to `pc=0`.
- HALT 0xE0:
  - `halted=1` after WRITEBACK;
  - `busy=0`;
  - toggling `run` gives no further `ir_load`;
  - reset clears `halted`.
- `halt_req` raised during EXECUTE of an ALU instruction:
  - the instruction completes, with `reg_write` pulsed;
  - then IDLE with `busy=0`;
  - `pc` advanced by 1.
- With `SEQ_SINGLE_STEP_EN`, one `step` pulse and `run=0`:
  - exactly one `ir_load` and a 4-cycle `busy` window;
  - `retired` +1;
  - a `step` during `busy` is ignored.
- `rst` asserted in EXECUTE:
  - `pc` returns to 0 asynchronously;
  - no `reg_write`;
  - `retired` unchanged at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
//   seq_state_e : sequencer FSM states
//   OP_*        : instruction class encodings held in ir[7:6]
//   ALU_OP_W    : width of the ALU function field ir[5:3]
//   HALT_BIT    : bit of a SYS instruction that selects HALT (1) or NOP (0)
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } seq_state_e;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam int ALU_OP_W = 3;
  localparam int HALT_BIT = 5;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction classifier for cpu_sequencer.
// Ports:
//   ir       in  8         latched instruction register
//   is_write out 1         instruction writes the register file (ALU, LDI)
//   is_jump  out 1         instruction is JMP
//   is_halt  out 1         instruction is SYS with the HALT bit set
//   target   out PC_WIDTH  jump target, ir[PC_WIDTH-1:0]
module seq_decode
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 4
) (
  input  logic [7:0]          ir,
  output logic                is_write,
  output logic                is_jump,
  output logic                is_halt,
  output logic [PC_WIDTH-1:0] target
);

  logic [1:0] op;
  logic       unused_ir;

  assign op        = ir[7:6];
  assign is_write  = (op == OP_ALU) || (op == OP_LDI);
  assign is_jump   = (op == OP_JMP);
  assign is_halt   = (op == OP_SYS) && ir[HALT_BIT];
  assign target    = ir[PC_WIDTH-1:0];
  // Not every IR bit feeds a decode term for every PC width.
  assign unused_ir = ^ir;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns the PC and steps each instruction
// through FETCH/DECODE/EXECUTE/WRITEBACK, driving the datapath strobes.
// Optional feature: define SEQ_SINGLE_STEP_EN to let a `step` pulse in IDLE
// execute exactly one instruction; otherwise `step` is ignored.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   run           level, execute back to back while high
//   step          one-cycle pulse, single-step from IDLE (feature-gated)
//   halt_req      level, finish current instruction then go IDLE
//   instruction   8-bit instruction word at pc (combinational)
//   pc            instruction address
//   ir_load       one-cycle strobe in FETCH
//   opcode        ir[7:6]
//   alu_op        ir[5:3]
//   reg_write     one-cycle register-file write strobe in WRITEBACK
//   pc_src        high in WRITEBACK of a JMP
//   busy          high in FETCH..WRITEBACK
//   halted        high in HALTED
//   retired       completed-instruction count, wraps at 256
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int          PC_WIDTH = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  input  logic                halt_req,
  input  logic [7:0]          instruction,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ir_load,
  output logic [1:0]          opcode,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                pc_src,
  output logic                busy,
  output logic                halted,
  output logic [7:0]          retired
);

  seq_state_e          state, next_state;
  logic [7:0]          ir;
  logic                step_mode, next_step_mode;
  logic                start_step;
  logic                is_write, is_jump, is_halt;
  logic [PC_WIDTH-1:0] target;

  seq_decode #(.PC_WIDTH(PC_WIDTH)) u_decode (
    .ir       (ir),
    .is_write (is_write),
    .is_jump  (is_jump),
    .is_halt  (is_halt),
    .target   (target)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign start_step = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign start_step  = 1'b0;
`endif

  always_comb begin
    next_state     = state;
    next_step_mode = step_mode;
    case (state)
      ST_IDLE: begin
        // halt_req dominates; run wins over step so a combined request
        // starts a free run rather than a single step.
        if (!halt_req) begin
          if (run) begin
            next_state     = ST_FETCH;
            next_step_mode = 1'b0;
          end else if (start_step) begin
            next_state     = ST_FETCH;
            next_step_mode = 1'b1;
          end
        end
      end
      ST_FETCH:   next_state = ST_DECODE;
      ST_DECODE:  next_state = ST_EXECUTE;
      ST_EXECUTE: next_state = ST_WRITEBACK;
      ST_WRITEBACK: begin
        if (is_halt)
          next_state = ST_HALTED;
        else if (run && !halt_req && !step_mode)
          next_state = ST_FETCH;
        else
          next_state = ST_IDLE;
      end
      ST_HALTED:  next_state = ST_HALTED;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from next_state so each is high for the whole
  // cycle spent in its state and clean of decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      step_mode <= 1'b0;
      pc        <= PC_WIDTH'(RESET_PC);
      ir        <= '0;
      ir_load   <= 1'b0;
      reg_write <= 1'b0;
      pc_src    <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= next_state;
      step_mode <= next_step_mode;
      ir_load   <= (next_state == ST_FETCH);
      reg_write <= (next_state == ST_WRITEBACK) && is_write;
      pc_src    <= (next_state == ST_WRITEBACK) && is_jump;
      if (state == ST_FETCH)
        ir <= instruction;
      if (state == ST_WRITEBACK) begin
        pc      <= is_jump ? target : pc + PC_WIDTH'(1);
        retired <= retired + 8'd1;
      end
    end
  end

  assign opcode = ir[7:6];
  assign alu_op = ir[3 +: ALU_OP_W];
  assign busy   = (state == ST_FETCH) || (state == ST_DECODE) ||
                  (state == ST_EXECUTE) || (state == ST_WRITEBACK);
  assign halted = (state == ST_HALTED);

endmodule
